// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - Writeback select encodings (WB_*), funct3 access encodings (F3_*)
//   - lsu_state_t: IDLE / REQ / WAIT / DONE
//   - is_misaligned(): alignment check for an access size and address low bits
package riscv_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // funct3[1:0] encodes the size; the reserved size code is held to word alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane helper for the load/store unit.
//   funct3     in  3   access size/sign
//   addr_lo    in  2   address byte offset
//   wdata      in  32  raw store data
//   rdata      in  32  raw bus read word
//   be         out 4   byte enables for the access
//   wdata_lane out 32  store data replicated onto every lane of its size
//   ld_data    out 32  selected and sign/zero-extended load value
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] ld_data
);

  logic [31:0] rshift_s;

  // Store lanes: replication lets the byte enables alone pick the target lane.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0000_0000;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    rshift_s = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{rshift_s[7]}}, rshift_s[7:0]};
      F3_H:    ld_data = {{16{rshift_s[15]}}, rshift_s[15:0]};
      F3_BU:   ld_data = {24'h00_0000, rshift_s[7:0]};
      F3_HU:   ld_data = {16'h0000, rshift_s[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues req/gnt/rvalid bus accesses for loads and
// stores, stalls the pipeline while an access is outstanding, and parks a
// finished result in a hold register while the MEM/WB register is frozen.
// Optional build macro: LSU_TIMEOUT_EN (abort accesses unanswered for
// TIMEOUT_CYCLES cycles and pulse o_bus_errM).
// Ports:
//   i_clk, i_rst_n (synchronous, active-low)
//   i_rd_wrenM/i_lsu_wrenM/i_wb_selM/i_funct3M/i_addrM/i_wdataM  EX/MEM controls and data
//   i_holdM                                                      MEM/WB not advancing
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/o_mem_be           bus request side
//   i_mem_gnt/i_mem_rvalid/i_mem_rdata                           bus response side
//   o_ld_dataM/o_rd_wrenM/o_stallM/o_misalignM/o_bus_errM        towards pipeline
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rd_wrenM,
  input  logic          i_lsu_wrenM,
  input  logic [1:0]    i_wb_selM,
  input  logic [2:0]    i_funct3M,
  input  logic [AW-1:0] i_addrM,
  input  logic [31:0]   i_wdataM,
  input  logic          i_holdM,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic          i_mem_gnt,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata,
  output logic [31:0]   o_ld_dataM,
  output logic          o_rd_wrenM,
  output logic          o_stallM,
  output logic          o_misalignM,
  output logic          o_bus_errM
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter");
  end

  lsu_state_t    state_r, state_nxt_s;
  logic          is_store_s, access_s, misalign_s, abort_s;
  logic [AW-1:0] addr_r, addr_sel_s;
  logic [2:0]    funct3_r, funct3_sel_s;
  logic [31:0]   wdata_r, wdata_sel_s;
  logic          we_r;
  logic [31:0]   hold_data_r;
  logic [3:0]    be_s;
  logic [31:0]   wdata_lane_s, ext_data_s;

  assign is_store_s = i_lsu_wrenM;
  assign access_s   = i_lsu_wrenM | (i_wb_selM == WB_MEM);
  assign misalign_s = is_misaligned(i_funct3M, i_addrM[1:0]);

  // Issue cycle uses live inputs; later states use the copy latched at issue.
  always_comb begin
    if (state_r == IDLE) begin
      addr_sel_s   = i_addrM;
      funct3_sel_s = i_funct3M;
      wdata_sel_s  = i_wdataM;
    end else begin
      addr_sel_s   = addr_r;
      funct3_sel_s = funct3_r;
      wdata_sel_s  = wdata_r;
    end
  end

  lsu_align u_align (
    .funct3     (funct3_sel_s),
    .addr_lo    (addr_sel_s[1:0]),
    .wdata      (wdata_sel_s),
    .rdata      (i_mem_rdata),
    .be         (be_s),
    .wdata_lane (wdata_lane_s),
    .ld_data    (ext_data_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_r;

  // Cycles spent in the current REQ/WAIT state; any state change restarts it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == REQ || state_r == WAIT) && (state_nxt_s == state_r)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  // A response arriving in the last allowed cycle still wins over the abort.
  always_comb begin
    if (tmo_cnt_r == TMO_LAST) begin
      case (state_r)
        REQ:     abort_s = !i_mem_gnt;
        WAIT:    abort_s = !i_mem_rvalid;
        default: abort_s = 1'b0;
      endcase
    end else begin
      abort_s = 1'b0;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; completion under i_holdM parks in DONE so the still-
  // presented instruction is not issued a second time.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s && !misalign_s) begin
          if (i_mem_gnt) begin
            if (is_store_s) begin
              state_nxt_s = i_holdM ? DONE : IDLE;
            end else begin
              state_nxt_s = WAIT;
            end
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
        end else if (i_mem_gnt) begin
          if (we_r) begin
            state_nxt_s = i_holdM ? DONE : IDLE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
        end else if (i_mem_rvalid) begin
          state_nxt_s = i_holdM ? DONE : IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        state_nxt_s = i_holdM ? DONE : IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic; reset forces the bus and pipeline signals quiet at once.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0000_0000;
    o_mem_be    = 4'b0000;
    o_ld_dataM  = 32'h0000_0000;
    o_rd_wrenM  = i_rd_wrenM;
    o_stallM    = 1'b0;
    o_misalignM = 1'b0;
    o_bus_errM  = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && misalign_s) begin
          o_misalignM = 1'b1;
          o_rd_wrenM  = 1'b0;
        end else if (access_s) begin
          o_mem_req   = 1'b1;
          o_mem_we    = is_store_s;
          o_mem_addr  = {addr_sel_s[AW-1:2], 2'b00};
          o_mem_be    = be_s;
          o_mem_wdata = wdata_lane_s;
          o_stallM    = !(i_mem_gnt && is_store_s);
        end else begin
          o_stallM = 1'b0;
        end
      end
      REQ: begin
        if (abort_s) begin
          o_bus_errM = 1'b1;
          o_rd_wrenM = 1'b0;
        end else begin
          o_mem_req   = 1'b1;
          o_mem_we    = we_r;
          o_mem_addr  = {addr_sel_s[AW-1:2], 2'b00};
          o_mem_be    = be_s;
          o_mem_wdata = wdata_lane_s;
          o_stallM    = !(i_mem_gnt && we_r);
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          o_ld_dataM = ext_data_s;
        end else if (abort_s) begin
          o_bus_errM = 1'b1;
          o_rd_wrenM = 1'b0;
        end else begin
          o_stallM = 1'b1;
        end
      end
      DONE: begin
        o_ld_dataM = hold_data_r;
      end
      default: begin
        o_stallM = 1'b0;
      end
    endcase
    if (!i_rst_n) begin
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = 32'h0000_0000;
      o_mem_be    = 4'b0000;
      o_ld_dataM  = 32'h0000_0000;
      o_rd_wrenM  = 1'b0;
      o_stallM    = 1'b0;
      o_misalignM = 1'b0;
      o_bus_errM  = 1'b0;
    end else begin
      o_misalignM = o_misalignM;
    end
  end

  // Request copy taken at issue, so REQ/WAIT do not depend on the EX/MEM register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_r   <= '0;
      funct3_r <= 3'b000;
      wdata_r  <= 32'h0000_0000;
      we_r     <= 1'b0;
    end else if (state_r == IDLE && access_s && !misalign_s) begin
      addr_r   <= i_addrM;
      funct3_r <= i_funct3M;
      wdata_r  <= i_wdataM;
      we_r     <= is_store_s;
    end else begin
      addr_r   <= addr_r;
      funct3_r <= funct3_r;
      wdata_r  <= wdata_r;
      we_r     <= we_r;
    end
  end

  // Hold register: captures the completing result on entry to DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_data_r <= 32'h0000_0000;
    end else if (state_nxt_s == DONE && state_r != DONE) begin
      hold_data_r <= o_ld_dataM;
    end else begin
      hold_data_r <= hold_data_r;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_wren_in, lsu_wren, hold, gnt, rvalid;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        req, mem_we, stall, misalign, bus_err, rd_wren_out;
  logic [31:0] mem_addr, mem_wdata, ld;
  logic [3:0]  be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(32), .TIMEOUT_CYCLES(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_wrenM(rd_wren_in), .i_lsu_wrenM(lsu_wren), .i_wb_selM(wb_sel),
    .i_funct3M(funct3), .i_addrM(addr), .i_wdataM(wdata), .i_holdM(hold),
    .o_mem_req(req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(be),
    .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_ld_dataM(ld), .o_rd_wrenM(rd_wren_out), .o_stallM(stall),
    .o_misalignM(misalign), .o_bus_errM(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    lsu_wren   = 1'b0;
    wb_sel     = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
    funct3     = 3'($urandom_range(0, 7));
    addr       = $urandom;
    wdata      = $urandom;
    rdata      = $urandom;
    rd_wren_in = 1'($urandom_range(0, 1));
    gnt        = 1'b0;
    rvalid     = 1'b0;
    hold       = 1'b0;
  endtask

  // Reference load: pick size bytes at the byte offset, extend by funct3[2].
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int size;
    logic [31:0] mask, v;
    size = 1 << f3[1:0];
    if (size >= 4) return rd;
    mask = (32'h1 << (8 * size)) - 32'h1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (f3[2] == 1'b0 && v[8 * size - 1] == 1'b1) v = v | ~mask;
    return v;
  endfunction

  // One access with bench-scheduled gnt (gd cycles after issue), rvalid (rdl after gnt)
  // and i_holdM held for hc cycles from completion. Spurious gnt/rvalid are
  // injected wherever the unit must ignore them.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rdl, input int hc, input logic rdw,
                           output logic [31:0] o_ld, output logic [3:0] o_be,
                           output logic [31:0] o_wd, output int nreq, output int nstall);
    int size, lo, c, last;
    bit mis, exp_req, exp_stall;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    size = 1 << f3[1:0];
    lo   = int'(a % 4);
    mis  = (int'(a % 4) % size) != 0;
    ebe  = 4'b0000;
    ewd  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= lo && i < lo + size) ebe[i] = 1'b1;
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    eld = ref_load(f3, a, rd);
    o_ld = 32'h0; o_be = 4'h0; o_wd = 32'h0; nreq = 0; nstall = 0;
    lsu_wren   = st;
    wb_sel     = st ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10) : 2'b01;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    rd_wren_in = rdw;
    gnt = 1'b0; rvalid = 1'b0; hold = 1'b0;
    if (mis) begin
      @(negedge clk);
      n_cmp++;
      if (misalign !== 1'b1 || req !== 1'b0 || stall !== 1'b0 || rd_wren_out !== 1'b0) begin
        n_err++;
        $display("FAIL misalign a=%h: misalign=%b req=%b stall=%b rd_wren=%b want 1 0 0 0", a, misalign, req, stall, rd_wren_out);
      end
      tick();
    end else begin
      c    = st ? gd : gd + rdl;
      last = c + hc;
      for (int k = 0; k <= last; k++) begin
        gnt = (k == gd) ? 1'b1 : ((k < gd) ? 1'b0 : 1'($urandom_range(0, 1)));
        if (!st && k > gd && k < c) rvalid = 1'b0;
        else if (!st && k == c)     rvalid = 1'b1;
        else                        rvalid = 1'($urandom_range(0, 1));
        rdata = (k == c) ? rd : $urandom;
        hold  = (k >= c && k < c + hc);
        @(negedge clk);
        exp_req   = (k <= gd);
        exp_stall = (k < c);
        if (stall === 1'b1) nstall++;
        if (req === 1'b1 && gnt === 1'b1) nreq++;
        n_cmp++;
        if (req !== exp_req || stall !== exp_stall) begin
          n_err++;
          $display("FAIL handshake a=%h k=%0d: req=%b stall=%b want req=%b stall=%b", a, k, req, stall, exp_req, exp_stall);
        end
        if (exp_req) begin
          n_cmp++;
          if (mem_addr !== (a & ~32'h3) || mem_we !== st || be !== ebe) begin
            n_err++;
            $display("FAIL bus a=%h k=%0d: addr=%h we=%b be=%h want %h %b %h", a, k, mem_addr, mem_we, be, a & ~32'h3, st, ebe);
          end
          if (st) begin
            n_cmp++;
            if (mem_wdata !== ewd) begin
              n_err++;
              $display("FAIL wdata a=%h k=%0d: got %h want %h", a, k, mem_wdata, ewd);
            end
          end
          if (k == 0) begin o_be = be; o_wd = mem_wdata; end
        end
        if (k == c) begin
          n_cmp++;
          if (rd_wren_out !== rdw || misalign !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL complete a=%h: rd_wren=%b misalign=%b bus_err=%b want %b 0 0", a, rd_wren_out, misalign, bus_err, rdw);
          end
        end
        if (!st && k >= c) begin
          n_cmp++;
          if (ld !== eld) begin
            n_err++;
            $display("FAIL ld_data a=%h f3=%0d k=%0d: got %h want %h", a, f3, k, ld, eld);
          end
          o_ld = ld;
        end
        tick();
      end
    end
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || stall !== 1'b0 || ld !== 32'h0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after a=%h: req=%b stall=%b ld=%h misalign=%b want 0 0 0 0", a, req, stall, ld, misalign);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lsu_wren = 1'b0; wb_sel = 2'b01; funct3 = 3'b010; addr = 32'h40;
    wdata = 32'h0; rdata = 32'h0; rd_wren_in = 1'b1; gnt = 1'b0; rvalid = 1'b1; hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b0 || mem_we !== 1'b0 || be !== 4'h0 || stall !== 1'b0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset: req=%b we=%b be=%h stall=%b mis=%b err=%b want all 0", req, mem_we, be, stall, misalign, bus_err);
      end
      tick();
    end
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || stall !== 1'b0 || ld !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset: req=%b stall=%b ld=%h want 0 0 0", req, stall, ld);
    end
    tick();
  endtask

  task automatic test_spec_vectors();
    logic [31:0] o_ld, o_wd;
    logic [3:0]  o_be;
    int nreq, nstall;
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 0, 1'b0, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (o_be !== 4'hF || o_wd !== 32'hDEADBEEF || nstall !== 0) begin
      n_err++;
      $display("FAIL sw_vec: be=%h wdata=%h stalls=%0d want F DEADBEEF 0", o_be, o_wd, nstall);
    end
    // Four-cycle access: three stalled cycles, the rvalid cycle releases the stall.
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 2, 1, 0, 1'b1, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (o_ld !== 32'hFFFFFF80 || nstall !== 3) begin
      n_err++;
      $display("FAIL lb_vec: ld=%h stalls=%0d want FFFFFF80 3", o_ld, nstall);
    end
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1, 1, 0, 1'b1, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (o_ld !== 32'h0000BEEF) begin
      n_err++;
      $display("FAIL lhu_vec: ld=%h want 0000BEEF", o_ld);
    end
    do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 1, 0, 1'b0, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (o_be !== 4'hC || o_wd !== 32'hABCDABCD) begin
      n_err++;
      $display("FAIL sh_vec: be=%h wdata=%h want C ABCDABCD", o_be, o_wd);
    end
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 0, 1'b1, o_ld, o_be, o_wd, nreq, nstall);
  endtask

  task automatic test_hold();
    logic [31:0] o_ld, o_wd;
    logic [3:0]  o_be;
    int nreq, nstall;
    do_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h13572468, 1, 1, 3, 1'b1, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (nreq !== 1 || o_ld !== 32'h13572468) begin
      n_err++;
      $display("FAIL hold_lw: granted_reqs=%0d ld=%h want 1 13572468", nreq, o_ld);
    end
    do_access(1'b1, 3'b000, 32'h109, 32'h000000A5, 32'h0, 2, 1, 2, 1'b0, o_ld, o_be, o_wd, nreq, nstall);
    n_cmp++;
    if (nreq !== 1) begin
      n_err++;
      $display("FAIL hold_sb: granted_reqs=%0d want 1", nreq);
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    wb_sel = 2'b01; funct3 = 3'b010; addr = 32'h200; gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_issue: req=%b stall=%b want 1 1", req, stall);
    end
    tick();
    rst_n = 1'b0; gnt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_wait: req=%b stall=%b want 0 0", req, stall);
    end
    tick();
    rst_n = 1'b1;
    set_idle();
    rvalid = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || stall !== 1'b0 || ld !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_rvalid: req=%b stall=%b ld=%h want 0 0 0", req, stall, ld);
    end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] o_ld, o_wd, a;
    logic [3:0]  o_be;
    logic [2:0]  f3;
    int nreq, nstall;
    bit st;
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_access(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), o_ld, o_be, o_wd, nreq, nstall);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        set_idle();
        tick();
      end
    end
  endtask

  task automatic test_timeout();
    int  ncyc;
    bit  exp_err, exp_stall, exp_req;
    ncyc = TMO_EN ? 64 : 70;
    set_idle();
    lsu_wren = 1'b1; funct3 = 3'b010; addr = 32'h300; wdata = 32'h11223344; rd_wren_in = 1'b1;
    for (int k = 0; k <= ncyc; k++) begin
      gnt = (!TMO_EN && k == ncyc);
      exp_err   = TMO_EN && (k == ncyc);
      exp_req   = !exp_err;
      exp_stall = (k != ncyc);
      @(negedge clk);
      n_cmp++;
      if (bus_err !== exp_err || stall !== exp_stall || req !== exp_req || rd_wren_out !== !exp_err) begin
        n_err++;
        $display("FAIL timeout k=%0d: err=%b stall=%b req=%b rd_wren=%b want %b %b %b %b",
                 k, bus_err, stall, req, rd_wren_out, exp_err, exp_stall, exp_req, !exp_err);
      end
      tick();
    end
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b0 || stall !== 1'b0 || req !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_after: err=%b stall=%b req=%b want 0 0 0", bus_err, stall, req);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_spec_vectors();
    test_hold();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
